// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous load, registered wrap pulse
// and a combinational cascade carry for chaining stages.
module mod_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] TOP_C  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_C  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             wrap_nxt_s;
    logic [WIDTH:0]   inc_s;
    logic [WIDTH-1:0] dec_s;
    logic [WIDTH-1:0] load_clamp_s;
    logic             at_top_s;
    logic             at_zero_s;

    // The extra bit keeps MODULUS = 2^WIDTH exact; an incremented value at or
    // beyond MODULUS also marks any illegal count as terminal on the way up.
    assign inc_s        = {1'b0, count_r} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_s        = count_r - ONE_C;
    assign at_top_s     = (inc_s >= MOD_C);
    assign at_zero_s    = (count_r == ZERO_C);
    assign load_clamp_s = ({1'b0, load_val} >= MOD_C) ? TOP_C : load_val;

    assign carry_out = en & ~load & (up ? at_top_s : at_zero_s);
    assign count     = count_r;
    assign wrap      = wrap_r;

    // Next-state selection: load beats count enable, which beats hold.
    always_comb begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
        if (load) begin
            count_nxt_s = load_clamp_s;
            wrap_nxt_s  = 1'b0;
        end else if (en) begin
            if (up) begin
                if (at_top_s) begin
                    count_nxt_s = ZERO_C;
                    wrap_nxt_s  = 1'b1;
                end else begin
                    count_nxt_s = inc_s[WIDTH-1:0];
                    wrap_nxt_s  = 1'b0;
                end
            end else begin
                if (at_zero_s) begin
                    count_nxt_s = TOP_C;
                    wrap_nxt_s  = 1'b1;
                end else begin
                    count_nxt_s = dec_s;
                    wrap_nxt_s  = 1'b0;
                end
            end
        end else begin
            count_nxt_s = count_r;
            wrap_nxt_s  = 1'b0;
        end
    end

    // State registers, cleared asynchronously while clear is low.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            count_r <= ZERO_C;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: a two-stage decade cascade plus MODULUS=16 and
// MODULUS=2 instances, checked every cycle against an arithmetic model.
module tb_mod_updown_counter;

    logic       clk   = 1'b0;
    logic       clear = 1'b1;
    logic       en    = 1'b0;
    logic       up    = 1'b0;
    logic       load  = 1'b0;
    logic [3:0] lv    = 4'd0;

    logic [3:0] c_lo, c_hi, c_16;
    logic [1:0] c_2;
    logic       w_lo, w_hi, w_16, w_2;
    logic       k_lo, k_hi, k_16, k_2;

    int  m_lo = 0, m_hi = 0, m_16 = 0, m_2 = 0;
    int  mw_lo = 0, mw_hi = 0, mw_16 = 0, mw_2 = 0;
    bit  chk_on = 1'b0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  hi_wraps;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(lv),
        .count(c_lo), .wrap(w_lo), .carry_out(k_lo));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .clear(clear), .en(k_lo), .up(up), .load(1'b0), .load_val(4'd0),
        .count(c_hi), .wrap(w_hi), .carry_out(k_hi));

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_16 (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(lv),
        .count(c_16), .wrap(w_16), .carry_out(k_16));

    mod_updown_counter #(.WIDTH(2), .MODULUS(2)) u_2 (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(lv[1:0]),
        .count(c_2), .wrap(w_2), .carry_out(k_2));

    function automatic int mnext(input int c, input bit e, input bit u, input bit ld,
                                 input int v, input int md);
        if (ld)     return (v >= md) ? md - 1 : v;
        else if (e) return u ? (c + 1) % md : (c + md - 1) % md;
        else        return c;
    endfunction

    function automatic int mwrap(input int c, input bit e, input bit u, input bit ld,
                                 input int md);
        if (ld || !e) return 0;
        return u ? int'(c == md - 1) : int'(c == 0);
    endfunction

    function automatic bit mcarry(input int c, input bit e, input bit u, input bit ld,
                                  input int md);
        return e && !ld && (u ? (c == md - 1) : (c == 0));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Reference model: next values follow modulo arithmetic on the current inputs.
    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            m_lo <= 0; m_hi <= 0; m_16 <= 0; m_2 <= 0;
            mw_lo <= 0; mw_hi <= 0; mw_16 <= 0; mw_2 <= 0;
        end else begin
            m_lo  <= mnext(m_lo, en, up, load, int'(lv), 10);
            mw_lo <= mwrap(m_lo, en, up, load, 10);
            m_hi  <= mnext(m_hi, mcarry(m_lo, en, up, load, 10), up, 1'b0, 0, 10);
            mw_hi <= mwrap(m_hi, mcarry(m_lo, en, up, load, 10), up, 1'b0, 10);
            m_16  <= mnext(m_16, en, up, load, int'(lv), 16);
            mw_16 <= mwrap(m_16, en, up, load, 16);
            m_2   <= mnext(m_2, en, up, load, int'(lv[1:0]), 2);
            mw_2  <= mwrap(m_2, en, up, load, 2);
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("lo count", 32'(c_lo), m_lo);
            check("lo wrap",  32'(w_lo), mw_lo);
            check("lo carry", 32'(k_lo), int'(mcarry(m_lo, en, up, load, 10)));
            check("hi count", 32'(c_hi), m_hi);
            check("hi wrap",  32'(w_hi), mw_hi);
            check("hi carry", 32'(k_hi),
                  int'(mcarry(m_hi, mcarry(m_lo, en, up, load, 10), up, 1'b0, 10)));
            check("m16 count", 32'(c_16), m_16);
            check("m16 wrap",  32'(w_16), mw_16);
            check("m16 carry", 32'(k_16), int'(mcarry(m_16, en, up, load, 16)));
            check("m2 count", 32'(c_2), m_2);
            check("m2 wrap",  32'(w_2), mw_2);
            check("m2 carry", 32'(k_2), int'(mcarry(m_2, en, up, load, 2)));
        end
    end

    initial begin
        #1 clear = 1'b0;
        repeat (2) cyc();
        clear = 1'b1; chk_on = 1'b1;
        en = 1'b1; up = 1'b1;
        repeat (7) cyc();
        @(negedge clk);
        check("pre-reset count", 32'(c_lo), 7);
        // Asynchronous clear between edges
        #2 clear = 1'b0;
        #1;
        check("async clear count", 32'(c_lo), 0);
        check("async clear wrap", 32'(w_lo), 0);
        check("async clear m16", 32'(c_16), 0);
        cyc();
        clear = 1'b1;
        repeat (3) cyc();
        en = 1'b0;
        @(negedge clk);
        check("three steps after release", 32'(c_lo), 3);

        // Up sequence 0..9 then wrap
        cyc();
        load = 1'b1; lv = 4'd0; en = 1'b1; up = 1'b1;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("up seq count", 32'(c_lo), i);
            check("up seq carry", 32'(k_lo), (i == 9) ? 1 : 0);
            cyc();
        end
        up = 1'b0;
        @(negedge clk);
        check("up wrap count", 32'(c_lo), 0);
        check("up wrap pulse", 32'(w_lo), 1);
        check("down carry at 0", 32'(k_lo), 1);
        cyc();
        @(negedge clk);
        check("down wrap count", 32'(c_lo), 9);
        check("down wrap pulse", 32'(w_lo), 1);
        cyc();
        @(negedge clk);
        check("down step count", 32'(c_lo), 8);
        check("down step wrap", 32'(w_lo), 0);

        // Load priority, clamp, and load at terminal count
        cyc();
        load = 1'b1; lv = 4'd4; en = 1'b1;
        cyc();
        lv = 4'd13;
        @(negedge clk);
        check("load 4", 32'(c_lo), 4);
        check("load wrap", 32'(w_lo), 0);
        cyc();
        up = 1'b1; lv = 4'd2;
        @(negedge clk);
        check("load clamp", 32'(c_lo), 9);
        check("carry masked by load", 32'(k_lo), 0);
        cyc();
        lv = 4'd5; en = 1'b0;
        @(negedge clk);
        check("load at 9", 32'(c_lo), 2);
        check("no wrap on load", 32'(w_lo), 0);

        // Direction toggling around 5
        cyc();
        load = 1'b0; en = 1'b1; up = 1'b1;
        @(negedge clk);
        check("toggle start", 32'(c_lo), 5);
        cyc();
        up = 1'b0;
        @(negedge clk);
        check("toggle up", 32'(c_lo), 6);
        cyc();
        up = 1'b1;
        @(negedge clk);
        check("toggle down", 32'(c_lo), 5);
        cyc();
        en = 1'b0;
        @(negedge clk);
        check("toggle up again", 32'(c_lo), 6);

        // Full-range modulus 16
        cyc();
        load = 1'b1; lv = 4'd15; en = 1'b1; up = 1'b1;
        cyc();
        load = 1'b0;
        @(negedge clk);
        check("m16 at 15", 32'(c_16), 15);
        check("m16 carry at 15", 32'(k_16), 1);
        check("lo clamp 15", 32'(c_lo), 9);
        cyc();
        en = 1'b0;
        @(negedge clk);
        check("m16 wrap count", 32'(c_16), 0);
        check("m16 wrap pulse", 32'(w_16), 1);

        // Modulus 2: wrap every other cycle
        cyc();
        load = 1'b1; lv = 4'd0;
        cyc();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (i == 4) en = 1'b0;
            @(negedge clk);
            check("m2 count", 32'(c_2), i % 2);
            check("m2 wrap", 32'(w_2), (i % 2 == 0) ? 1 : 0);
        end

        // Cascade: 100 up-steps through 99 back to 00
        cyc();
        clear = 1'b0;
        cyc();
        clear = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
        hi_wraps = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            if (i == 100) en = 1'b0;
            @(negedge clk);
            if (w_hi) hi_wraps++;
            if (i == 99) begin
                check("cascade 99 lo", 32'(c_lo), 9);
                check("cascade 99 hi", 32'(c_hi), 9);
            end
            if (i == 100) begin
                check("cascade 00 lo", 32'(c_lo), 0);
                check("cascade 00 hi", 32'(c_hi), 0);
                check("cascade hi wrap", 32'(w_hi), 1);
            end
        end
        check("cascade hi wrap count", 32'(hi_wraps), 1);

        // Randomised traffic with occasional mid-cycle clears
        for (int i = 0; i < 3000; i++) begin
            cyc();
            en    = ($urandom_range(0, 3) != 0);
            up    = 1'($urandom);
            load  = ($urandom_range(0, 15) == 0);
            lv    = 4'($urandom);
            clear = ($urandom_range(0, 199) != 0);
        end
        cyc();
        clear = 1'b1;
        cyc();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
